phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: holds a DUT in reset, then steps through NUM_PHASES timed test
// phases per run with abort and watchdog timeout.
`default_nettype none

module phase_sequencer #(
  parameter int NUM_PHASES     = 3,
  parameter int CNT_W          = 16,
  parameter int RST_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [NUM_PHASES*CNT_W-1:0] phase_len_i,
  output logic                        dut_rst_n_o,
  output logic                        busy_o,
  output logic [IDX_W-1:0]            phase_idx_o,
  output logic                        phase_done_o,
  output logic                        all_done_o,
  output logic                        timeout_o,
  output logic [CNT_W-1:0]            cycle_cnt_o
);

  localparam int                RC_W     = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    RUN      = 3'd2,
    DONE     = 3'd3,
    TIMEOUT  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [RC_W-1:0]   rst_cnt;
  logic [IDX_W-1:0]  phase_idx;
  logic [CNT_W-1:0]  phase_cnt;
  logic [CNT_W-1:0]  cur_len;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              phase_last;
  logic              start_run;
  logic              advance;

  always_comb begin
    cur_len = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (phase_idx == IDX_W'(k)) cur_len = phase_len_i[k*CNT_W +: CNT_W];
    end
  end

  // A zero length compares as "already at the end", so it lasts one cycle.
  assign phase_last = ({1'b0, phase_cnt} + (CNT_W+1)'(1)) >= {1'b0, cur_len};

  always_comb begin
    state_nx     = state;
    phase_done_o = 1'b0;
    start_run    = 1'b0;
    advance      = 1'b0;
    case (state)
      RST_HOLD: if (rst_cnt == RC_LAST) state_nx = IDLE;
      IDLE, DONE, TIMEOUT: begin
        if (start_i) begin
          state_nx  = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nx = IDLE;
        end else begin
          phase_done_o = phase_last;
          if (phase_last && (phase_idx == IDX_LAST)) begin
            state_nx = DONE;
          end else if (to_cnt == TO_LAST) begin
            state_nx = TIMEOUT;
          end else begin
            advance = phase_last;
          end
        end
      end
      default: state_nx = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_HOLD;
      rst_cnt   <= '0;
      phase_idx <= '0;
      phase_cnt <= '0;
      to_cnt    <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == RST_HOLD && state_nx == RST_HOLD) rst_cnt <= rst_cnt + 1'b1;
      if (state_nx != RST_HOLD && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
      if (start_run) begin
        phase_idx <= '0;
        phase_cnt <= '0;
        to_cnt    <= '0;
      end else if (state == RUN && state_nx == RUN) begin
        to_cnt <= to_cnt + 1'b1;
        if (advance) begin
          phase_idx <= phase_idx + 1'b1;
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
      end
    end
  end

  assign dut_rst_n_o = (state != RST_HOLD);
  assign busy_o      = (state == RUN);
  assign all_done_o  = (state == DONE);
  assign timeout_o   = (state == TIMEOUT);
  assign phase_idx_o = phase_idx;
  assign cycle_cnt_o = cycle_cnt;

endmodule

`default_nettype wire
